// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: one outstanding SRAM word fetch, one-entry hand-off to the IDU,
// redirect from EXU at any time with stale-response suppression.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request, no instruction
// REQ   | request for pc presented to SRAM, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid (dropped if stale)
// HOLD  | instruction and its pc presented to IDU until inst_ready
module ysyx_24080014_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic [31:0] perf_fetch_cnt
);

   typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        stale_q, stale_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] perf_q, perf_d;
   logic [31:0] redir_pc;
   logic        unused_rpc_lsb;

   assign redir_pc       = {redirect_pc[31:2], 2'b00};
   assign unused_rpc_lsb = ^redirect_pc[1:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stale_d = stale_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      perf_d  = perf_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_REQ;
            if (redirect_valid) pc_d = redir_pc;
         end
         ST_REQ: begin
            if (mem_req_ready) state_d = ST_WAIT;
            // an accepted request for the old pc must have its response thrown away
            if (redirect_valid) begin
               pc_d    = redir_pc;
               stale_d = mem_req_ready;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
               if (mem_rsp_valid) begin
                  stale_d = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  stale_d = 1'b1;
               end
            end else if (mem_rsp_valid) begin
               if (stale_q) begin
                  stale_d = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  inst_d  = mem_rsp_data;
                  ipc_d   = pc_q;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (inst_ready) perf_d = perf_q + 32'd1;
            if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = ST_REQ;
            end else if (inst_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         stale_q <= 1'b0;
         inst_q  <= 32'd0;
         ipc_q   <= 32'd0;
         perf_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stale_q <= stale_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         perf_q  <= perf_d;
      end
   end

   assign mem_req_valid  = (state_q == ST_REQ);
   assign mem_addr       = pc_q;
   assign inst_valid     = (state_q == ST_HOLD);
   assign inst_out       = inst_q;
   assign inst_pc        = ipc_q;
   assign perf_fetch_cnt = perf_q;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Bench for the fetch unit: directed scenarios then random traffic, all checked against
// a pc-sequence scoreboard and a latency-programmable SRAM model.
module tb_ysyx_24080014_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_out, inst_pc, perf_fetch_cnt;

   ysyx_24080014_ifu #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
      .inst_pc(inst_pc), .perf_fetch_cnt(perf_fetch_cnt)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cycnt = 0;
   int          idle = 0;
   int          xfer_t[$];
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] xfer_cnt = 32'd0;
   bit          sram_auto = 1'b1;
   bit          sram_busy = 1'b0;
   bit          rand_spur = 1'b0;
   logic [31:0] sram_addr = 32'd0;
   int          sram_lat = 0;
   int          lat_cfg = 1;
   logic [31:0] p, io, ip, a0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // SRAM response for the coming edge
   task automatic drive_rsp();
      if (sram_auto) begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = 32'd0;
         if (sram_busy && sram_lat == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word(sram_addr);
         end else if (!sram_busy && rand_spur && $urandom_range(0, 7) == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom;
         end
      end
   endtask

   // Observe outputs/inputs for the coming edge, update models, advance one cycle
   task automatic cyc();
      if (!rst) begin
         exp_pc   = RST_PC;
         xfer_cnt = 32'd0;
      end else begin
         chk("perf_cnt", perf_fetch_cnt, xfer_cnt);
         chk("req_inst_excl", 32'(mem_req_valid & inst_valid), 32'd0);
         if (mem_req_valid) chk("req_addr", mem_addr, exp_pc);
         if (inst_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_out", inst_out, word(exp_pc));
         end
         if (inst_valid && inst_ready) begin
            xfer_cnt++;
            exp_pc = exp_pc + 32'd4;
            xfer_t.push_back(cycnt);
            idle = 0;
         end else begin
            idle++;
         end
         if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      end
      if (sram_auto) begin
         if (mem_rsp_valid && sram_busy) sram_busy = 1'b0;
         else if (sram_busy && sram_lat > 0) sram_lat--;
         if (mem_req_valid && mem_req_ready) begin
            sram_busy = 1'b1;
            sram_addr = mem_addr;
            sram_lat  = lat_cfg - 1;
         end
      end
      @(negedge clk);
      cycnt++;
   endtask

   task automatic wait_inst();
      for (int i = 0; i < 30 && !inst_valid; i++) begin
         drive_rsp();
         cyc();
      end
      chk("inst_valid_timeout", 32'(inst_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
      redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_addr", mem_addr, RST_PC);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_out", inst_out, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_perf", perf_fetch_cnt, 32'd0);

      // back-to-back fetch, 1-cycle SRAM, IDU always ready
      mem_req_ready = 1'b1; inst_ready = 1'b1; lat_cfg = 1; rst = 1'b1;
      chk("boot_no_req", 32'(mem_req_valid), 32'd0);
      drive_rsp(); cyc();
      chk("first_req", 32'(mem_req_valid), 32'd1);
      xfer_t.delete();
      for (int i = 0; i < 40 && xfer_t.size() < 3; i++) begin
         drive_rsp(); cyc();
      end
      chk("t1_xfers", 32'(xfer_t.size()), 32'd3);
      if (xfer_t.size() == 3) begin
         chk("t1_gap0", 32'(xfer_t[1] - xfer_t[0]), 32'd3);
         chk("t1_gap1", 32'(xfer_t[2] - xfer_t[1]), 32'd3);
      end
      chk("t1_perf", perf_fetch_cnt, 32'd3);

      // IDU back-pressure in HOLD
      inst_ready = 1'b0;
      wait_inst();
      io = inst_out; ip = inst_pc;
      repeat (5) begin
         drive_rsp(); cyc();
         chk("hold_valid", 32'(inst_valid), 32'd1);
         chk("hold_out", inst_out, io);
         chk("hold_pc", inst_pc, ip);
         chk("hold_no_req", 32'(mem_req_valid), 32'd0);
      end
      inst_ready = 1'b1; p = perf_fetch_cnt;
      drive_rsp(); cyc();
      chk("hold_one_xfer", perf_fetch_cnt, p + 32'd1);
      chk("hold_released", 32'(inst_valid), 32'd0);

      // redirect in WAIT, stale response two edges later
      sram_auto = 1'b0; mem_rsp_valid = 1'b0;
      chk("t3_in_req", 32'(mem_req_valid), 32'd1);
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; mem_req_ready = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      chk("t3_wait_no_req", 32'(mem_req_valid), 32'd0);
      cyc();
      chk("t3_wait_no_inst", 32'(inst_valid), 32'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
      cyc();
      mem_rsp_valid = 1'b0;
      chk("t3_dropped", 32'(inst_valid), 32'd0);
      chk("t3_new_req", 32'(mem_req_valid), 32'd1);
      chk("t3_new_addr", mem_addr, 32'h8000_0100);
      sram_auto = 1'b1; sram_busy = 1'b0; mem_req_ready = 1'b1;
      wait_inst();
      chk("t3_inst_pc", inst_pc, 32'h8000_0100);

      // redirect coincident with a HOLD transfer
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0203; p = perf_fetch_cnt;
      drive_rsp(); cyc();
      redirect_valid = 1'b0;
      chk("t4_perf", perf_fetch_cnt, p + 32'd1);
      chk("t4_req", 32'(mem_req_valid), 32'd1);
      chk("t4_addr", mem_addr, 32'h8000_0200);

      // SRAM stall in REQ, redirect during stall
      mem_req_ready = 1'b0; a0 = mem_addr;
      repeat (4) begin
         drive_rsp(); cyc();
         chk("stall_req", 32'(mem_req_valid), 32'd1);
         chk("stall_addr", mem_addr, a0);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
      drive_rsp(); cyc();
      redirect_valid = 1'b0;
      chk("stall_redir_req", 32'(mem_req_valid), 32'd1);
      chk("stall_redir_addr", mem_addr, 32'h8000_0400);

      // reset during WAIT, late response after release
      mem_req_ready = 1'b1; lat_cfg = 4;
      drive_rsp(); cyc();
      chk("t6_in_wait", 32'(mem_req_valid | inst_valid), 32'd0);
      rst = 1'b0;
      #1;
      chk("t6_rst_addr", mem_addr, RST_PC);
      chk("t6_rst_perf", perf_fetch_cnt, 32'd0);
      chk("t6_rst_inst_pc", inst_pc, 32'd0);
      chk("t6_rst_req", 32'(mem_req_valid), 32'd0);
      lat_cfg = 1;
      repeat (2) begin drive_rsp(); cyc(); end
      rst = 1'b1;
      drive_rsp(); cyc();
      chk("t6_restart_req", 32'(mem_req_valid), 32'd1);
      chk("t6_restart_addr", mem_addr, RST_PC);
      wait_inst();
      chk("t6_first_pc", inst_pc, RST_PC);
      chk("t6_perf_zero", perf_fetch_cnt, 32'd0);

      // random traffic
      rand_spur = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         mem_req_ready  = ($urandom_range(0, 2) != 0);
         inst_ready     = ($urandom_range(0, 2) != 0);
         lat_cfg        = $urandom_range(1, 4);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
         drive_rsp(); cyc();
         chk("liveness", 32'(idle < 200), 32'd1);
      end
      redirect_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_24080014_ifu.md
# ysyx_24080014_ifu

Instruction fetch unit feeding the decode stage: holds the PC, issues one word-read request at a time to the instruction SRAM over a valid/ready request channel, captures the returned word, and presents it with its PC to the IDU through a valid/ready handshake. It accepts a redirect (jump/branch target) from the execute stage at any time and discards any in-flight response that is made stale by that redirect. At most one fetch is outstanding; there is no prefetch queue.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req_valid  out  1  fetch request to instruction SRAM
- mem_req_ready  in  1  SRAM accepts request this cycle
- mem_addr  out  32  fetch address, equals PC; stable while mem_req_valid=1 and not accepted, unless redirected
- mem_rsp_valid  in  1  SRAM returns data this cycle
- mem_rsp_data  in  32  returned instruction word
- redirect_valid  in  1  EXU redirect request, single-cycle pulse
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  instruction available to IDU
- inst_ready  in  1  IDU accepts instruction
- inst_out  out  32  instruction word
- inst_pc  out  32  PC of inst_out
- perf_fetch_cnt  out  32  count of instructions delivered to IDU

## Operation
- States: BOOT, REQ, WAIT, HOLD; all outputs decoded from registers (no combinational input-to-output paths).
- BOOT: entered on reset; mem_req_valid=0, inst_valid=0; next edge → REQ.
- REQ: mem_req_valid=1, mem_addr=pc. mem_req_ready=1 → WAIT.
- WAIT: mem_req_valid=0. mem_rsp_valid=1 → latch mem_rsp_data into inst_out, pc into inst_pc, → HOLD. If the stale flag is set, the response is dropped, stale cleared, → REQ.
- HOLD: inst_valid=1; inst_out/inst_pc stable. inst_valid&inst_ready → pc=pc+4, perf_fetch_cnt+1, → REQ.
- Redirect (redirect_valid=1), priority over all other transitions:
  - BOOT: pc=redirect_pc, → REQ.
  - REQ: pc=redirect_pc, stay REQ; if mem_req_ready was also 1 that cycle, → WAIT with stale=1 (accepted request belongs to old PC).
  - WAIT: pc=redirect_pc, stale=1; if mem_rsp_valid also 1 that cycle, response dropped, → REQ directly, stale=0.
  - HOLD: held instruction discarded, pc=redirect_pc, → REQ. If inst_ready=1 the same cycle, the transfer counts (perf_fetch_cnt+1) but next pc is redirect_pc, not pc+4.
- mem_rsp_valid outside WAIT: ignored.
- pc+4 and perf_fetch_cnt wrap modulo 2^32.

## Timing
- Reset (rst=0, async): state=BOOT, pc=RESET_PC, stale=0, mem_req_valid=0, mem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, perf_fetch_cnt=0.
- First mem_req_valid=1 in the second cycle after rst rises (one cycle in BOOT).
- Request accepted at edge N → WAIT from N; response at edge M>N → inst_valid=1 from M.
- Best case with SRAM answering one cycle after acceptance and IDU always ready: one instruction every 3 cycles (REQ, WAIT, HOLD).
- Reset asserted mid-operation: all state cleared immediately; any later SRAM response is ignored (arrives in BOOT/REQ).

## Test plan
- Reset then SRAM always ready, 1-cycle response, IDU always ready: inst_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, one per 3 cycles; perf_fetch_cnt=3 after third transfer.
- IDU holds inst_ready=0 for 5 cycles in HOLD: inst_valid, inst_out, inst_pc stable; mem_req_valid stays 0; after ready, exactly one transfer.
- Redirect to 0x8000_0100 while in WAIT, response 0xDEAD_BEEF arrives 2 cycles later: word dropped, never on inst_valid; next mem_addr=0x8000_0100.
- Redirect to 0x8000_0203 in the same cycle as an HOLD transfer: transfer counted, next mem_addr=0x8000_0200.
- mem_req_ready=0 for 4 cycles in REQ: mem_req_valid=1, mem_addr constant; redirect during stall changes mem_addr to the new target next cycle.
- Assert rst during WAIT, then SRAM returns data after release: data ignored, fetch restarts at RESET_PC, perf_fetch_cnt=0.
